// File: rtl/join_rd_splitter_if.sv
// Read-request record used on the join read path and the valid/ready metadata
// channel that carries it between the request queues, the splitter and the host port.
package join_rd_splitter_pkg;
  localparam int VADDR_BITS = 48;
  localparam int LEN_BITS   = 28;
  localparam int PID_BITS   = 6;
  localparam int CTL_BITS   = 1;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic [PID_BITS-1:0]   pid;
    logic [CTL_BITS-1:0]   ctl;
  } req_t;
endpackage

interface metaIntf;
  logic                      valid;
  logic                      ready;
  join_rd_splitter_pkg::req_t data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/join_rd_splitter.sv
// Round-robin arbiter over the S/R read-request queues that cuts each request into
// XFER_BYTES-aligned chunks and limits outstanding chunks per source with credits.
module join_rd_splitter
  import join_rd_splitter_pkg::*;
#(
  parameter int XFER_BYTES    = 4096,
  parameter int N_OUTSTANDING = 8
) (
  input  logic aclk,
  input  logic areset,
  metaIntf.s   s_req [2],
  metaIntf.m   m_req,
  output logic m_src,
  input  logic done_valid,
  input  logic done_src,
  output logic cnt_err
);

  localparam logic [VADDR_BITS-1:0] XFER_MASK = VADDR_BITS'(XFER_BYTES - 1);
  localparam logic [LEN_BITS:0]     XFER_SIZE = (LEN_BITS + 1)'(XFER_BYTES);
  localparam logic [7:0]            CREDITS   = 8'(N_OUTSTANDING);

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } state_t;

  state_t                state_q, state_d;
  logic [VADDR_BITS-1:0] vaddr_q, vaddr_d;
  logic [LEN_BITS-1:0]   rem_q,   rem_d;
  logic [PID_BITS-1:0]   pid_q,   pid_d;
  logic [CTL_BITS-1:0]   ctl_q,   ctl_d;
  logic                  src_q,   src_d;
  logic                  rr_q,    rr_d;
  logic [7:0]            cnt_q [2];
  logic [7:0]            cnt_d [2];
  logic                  err_q,   err_d;

  logic [1:0]          in_valid;
  logic [1:0]          in_ready;
  req_t                in_data [2];
  logic                gnt;
  logic [LEN_BITS-1:0] chunk;
  logic                last;
  logic                credit_ok;
  logic                out_valid;
  logic                issue;
  logic [1:0]          inc_v;
  logic [1:0]          dec_v;

  // Bytes left before the next XFER_BYTES boundary, clipped to what remains.
  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [VADDR_BITS-1:0] va,
                                                    input logic [LEN_BITS-1:0]   rem);
    logic [LEN_BITS:0] bound;
    bound = XFER_SIZE - (LEN_BITS + 1)'(va & XFER_MASK);
    return ({1'b0, rem} < bound) ? rem : bound[LEN_BITS-1:0];
  endfunction

  assign in_valid[0]    = s_req[0].valid;
  assign in_valid[1]    = s_req[1].valid;
  assign in_data[0]     = s_req[0].data;
  assign in_data[1]     = s_req[1].data;
  assign s_req[0].ready = in_ready[0];
  assign s_req[1].ready = in_ready[1];

  assign chunk     = chunk_len(vaddr_q, rem_q);
  assign last      = (chunk == rem_q);
  assign credit_ok = (cnt_q[src_q] < CREDITS);

  // Output fields come straight from registers, so they hold while stalled.
  assign m_req.valid      = out_valid;
  assign m_req.data.vaddr = vaddr_q;
  assign m_req.data.len   = chunk;
  assign m_req.data.pid   = pid_q;
  assign m_req.data.ctl   = last ? ctl_q : '0;
  assign m_src            = src_q;
  assign cnt_err          = err_q;

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    rem_d     = rem_q;
    pid_d     = pid_q;
    ctl_d     = ctl_q;
    src_d     = src_q;
    rr_d      = rr_q;
    in_ready  = '0;
    out_valid = 1'b0;
    issue     = 1'b0;
    gnt       = in_valid[rr_q] ? rr_q : ~rr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!areset && in_valid[gnt]) begin
          in_ready[gnt] = 1'b1;
          vaddr_d       = in_data[gnt].vaddr;
          rem_d         = in_data[gnt].len;
          pid_d         = in_data[gnt].pid;
          ctl_d         = in_data[gnt].ctl;
          src_d         = gnt;
          rr_d          = ~gnt;
          if (in_data[gnt].len != '0) begin
            state_d = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        out_valid = credit_ok && !areset;
        if (out_valid && m_req.ready) begin
          issue   = 1'b1;
          vaddr_d = vaddr_q + VADDR_BITS'(chunk);
          rem_d   = rem_q - chunk;
          if (last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inc_v[0] = issue && !src_q;
  assign inc_v[1] = issue &&  src_q;
  assign dec_v[0] = done_valid && !done_src;
  assign dec_v[1] = done_valid &&  done_src;

  // A done with nothing outstanding is clamped at zero and flagged.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == 8'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vaddr_q  <= '0;
      rem_q    <= '0;
      pid_q    <= '0;
      ctl_q    <= '0;
      src_q    <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      err_q    <= 1'b0;
    end else begin
      vaddr_q  <= vaddr_d;
      rem_q    <= rem_d;
      pid_q    <= pid_d;
      ctl_q    <= ctl_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/join_rd_splitter.md
# join_rd_splitter

Read-request splitter and arbiter placed directly downstream of the join control slave's R/S request queues, in front of the host read-request port. It round-robins between the two `req_t` read-request streams and cuts each request into chunks that never cross an `XFER_BYTES` boundary. It tags every chunk with its source index and enforces a per-source cap on outstanding chunks, using completion pulses from the data path.

## Interface
Parameters:
- `XFER_BYTES`, 4096: maximum chunk size and alignment boundary; must be a power of two.
- `N_OUTSTANDING`, 8: maximum issued but not completed chunks per source, range 1..255.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  reset, asynchronous, active-high.
- `s_req[2]`  metaIntf.s  req_t  input requests; index 0 = S, index 1 = R; fields `vaddr`, `len`, `pid`, `ctl`.
- `m_req`  metaIntf.m  req_t  chunked request to the host read port.
- `m_src`  out  1  source index of the current `m_req` chunk; valid while `m_req.valid`.
- `done_valid`  in  1  one-cycle pulse: one chunk of `done_src` has completed.
- `done_src`  in  1  source index qualified by `done_valid`.
- `cnt_err`  out  1  sticky flag: `done_valid` arrived while the counter for `done_src` was 0.

## Operation
FSM states are ST_IDLE and ST_SPLIT.

ST_IDLE:
- Candidate sources are those with `s_req[i].valid`.
- Grant goes to `rr_ptr` if it is a candidate, otherwise to the other source.
- Granted `s_req[i].ready` = 1 combinationally, for exactly the accept cycle.
- On accept, latch `vaddr`, `rem = len`, `pid`, `ctl`, and `src = i`. Set `rr_ptr = ~i`.
- If `len == 0`: consume the request, emit nothing, stay in ST_IDLE.
- Otherwise go to ST_SPLIT.

ST_SPLIT:
- `bound = XFER_BYTES - (vaddr mod XFER_BYTES)`.
- `chunk = min(rem, bound)`.
- `m_req.data.vaddr = vaddr`, `m_req.data.len = chunk`, `m_req.data.pid = pid`.
- `m_req.data.ctl = ctl` only when `chunk == rem` (last chunk); 0 on earlier chunks.
- `m_req.valid = (out_cnt[src] < N_OUTSTANDING)`.
- On the `m_req` handshake: `vaddr += chunk`, `rem -= chunk`, `out_cnt[src]++`.
- If `chunk == rem` at the handshake, return to ST_IDLE.

Outstanding counters:
- `out_cnt[0..1]` are 8 bits each.
- Issue increments the counter; `done_valid` decrements `out_cnt[done_src]`.
- Issue and done to the same source in the same cycle: counter unchanged.
- Done when the counter is 0: counter stays 0, `cnt_err` is set and stays set until reset.

Arithmetic and width rules:
- `vaddr` arithmetic is VADDR_BITS wide and wraps modulo 2^VADDR_BITS.
- `rem` and `chunk` are LEN_BITS wide.
- `bound` is computed in LEN_BITS + 1 bits.

Data hold rule: while `m_req.valid && !m_req.ready`, `m_req.data` and `m_src` are held stable.

## Timing
- Reset values, applied immediately on `areset` and without waiting for a clock edge:
  - state = ST_IDLE, `rr_ptr = 0`, `out_cnt = 0`, `cnt_err = 0`.
  - `m_req.valid = 0`, `s_req[*].ready = 0`.
  - Latched fields = 0.
- Latency: the first chunk is valid on the cycle after the accept.
- One chunk is issued per cycle while `m_req.ready` is high and credits are available.
- The next input can be accepted in the cycle after the last-chunk handshake, so an idle bubble of ≥1 cycle separates requests.
- `m_req.valid` may deassert without a handshake only when the credit limit is reached. It re-asserts the cycle after a `done_valid` frees a slot, because the counter is registered.
- `s_req[*].ready` is never asserted in ST_SPLIT.
- Reset asserted mid-split discards the current request and all counters.

## Test plan
- Single request, S, `vaddr=0x1000`, `len=10000`, `ready=1` -> chunks (0x1000,4096,ctl0), (0x2000,4096,ctl0), (0x3000,1808,ctl1) on consecutive cycles; `m_src=0`.
- Unaligned request, `vaddr=0x0F00`, `len=0x300`, `ctl=1` -> chunks (0x0F00,0x100,ctl0), (0x1000,0x200,ctl1).
- Arbitration: S and R each hold 3 one-chunk requests valid from cycle 0 -> issue order S,R,S,R,S,R; `m_src` alternates 0,1.
- Credit limit, `N_OUTSTANDING=4`: 6-chunk request, `ready=1`, no done -> exactly 4 chunks issued, then `valid` stays 0. One `done_valid`/`done_src=0` -> 5th chunk issued the next cycle.
- Zero length: `len=0` request on R followed by a `len=64` request on S -> R is consumed with no `m_req` output; single chunk (64) issued with `m_src=0`.
- Error and reset: `done_valid` with `out_cnt=0` -> `cnt_err=1`. Then `areset` asserted mid-split -> `m_req.valid=0` and `cnt_err=0` immediately; the first request after release starts from its own `vaddr`.
